ex_mem: RTL and testbench

EX_MEM -- requirements
Module: ex_mem

---
 rtl/ex_mem.sv | 86 ++++++++
 tb/tb_ex_mem.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: registers execute-stage GPR/HILO results for the
// memory stage and carries multiply-accumulate progress across execute stalls.
module ex_mem (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_ex,
  input  logic        stall_mem,
  input  logic        flush,
  input  logic [4:0]  ex_w_reg_addr,
  input  logic [31:0] ex_w_reg_data,
  input  logic        ex_w_reg_en,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic        ex_hilo_wen,
  input  logic [63:0] ex_hilo_temp,
  input  logic [1:0]  ex_cnt,
  output logic [4:0]  mem_w_reg_addr,
  output logic [31:0] mem_w_reg_data,
  output logic        mem_w_reg_en,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_hilo_wen,
  output logic        mem_valid,
  output logic [63:0] hilo_temp_out,
  output logic [1:0]  cnt_out
);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        en;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        hilo_wen;
  } slot_t;

  slot_t       w_in;
  slot_t       r_slot;
  logic        r_valid;
  logic [63:0] r_hilo_temp;
  logic [1:0]  r_cnt;
  logic        w_bubble;
  logic        w_capture;

  assign w_in      = '{addr: ex_w_reg_addr, data: ex_w_reg_data, en: ex_w_reg_en,
                       hi: ex_hi, lo: ex_lo, hilo_wen: ex_hilo_wen};
  assign w_bubble  = stall_ex & ~stall_mem;
  // stall_ex=0 with stall_mem=1 cannot legally occur; it falls through to hold.
  assign w_capture = ~stall_ex & ~stall_mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot      <= '0;
      r_valid     <= 1'b0;
      r_hilo_temp <= '0;
      r_cnt       <= '0;
    end else if (flush) begin
      r_slot      <= '0;
      r_valid     <= 1'b0;
      r_hilo_temp <= '0;
      r_cnt       <= '0;
    end else if (w_bubble) begin
      // Bubble keeps the multiply-accumulate partial product alive for execute.
      r_slot      <= '0;
      r_valid     <= 1'b0;
      r_hilo_temp <= ex_hilo_temp;
      r_cnt       <= ex_cnt;
    end else if (w_capture) begin
      r_slot      <= w_in;
      r_valid     <= 1'b1;
      r_hilo_temp <= '0;
      r_cnt       <= '0;
    end
  end

  assign mem_w_reg_addr = r_slot.addr;
  assign mem_w_reg_data = r_slot.data;
  assign mem_w_reg_en   = r_slot.en;
  assign mem_hi         = r_slot.hi;
  assign mem_lo         = r_slot.lo;
  assign mem_hilo_wen   = r_slot.hilo_wen;
  assign mem_valid      = r_valid;
  assign hilo_temp_out  = r_hilo_temp;
  assign cnt_out        = r_cnt;

endmodule

// File: tb/tb_ex_mem.sv
// Directed bench for ex_mem: a behavioural slot model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_ex_mem;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_ex = 1'b0, stall_mem = 1'b0, flush = 1'b0;
  logic [4:0]  ex_w_reg_addr = '0;
  logic [31:0] ex_w_reg_data = '0;
  logic        ex_w_reg_en = 1'b0;
  logic [31:0] ex_hi = '0, ex_lo = '0;
  logic        ex_hilo_wen = 1'b0;
  logic [63:0] ex_hilo_temp = '0;
  logic [1:0]  ex_cnt = '0;
  logic [4:0]  mem_w_reg_addr;
  logic [31:0] mem_w_reg_data;
  logic        mem_w_reg_en;
  logic [31:0] mem_hi, mem_lo;
  logic        mem_hilo_wen, mem_valid;
  logic [63:0] hilo_temp_out;
  logic [1:0]  cnt_out;

  int errors = 0;
  int checks = 0;

  ex_mem dut (
    .clk(clk), .rst_n(rst_n), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
    .ex_w_reg_addr(ex_w_reg_addr), .ex_w_reg_data(ex_w_reg_data), .ex_w_reg_en(ex_w_reg_en),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_hilo_wen(ex_hilo_wen),
    .ex_hilo_temp(ex_hilo_temp), .ex_cnt(ex_cnt),
    .mem_w_reg_addr(mem_w_reg_addr), .mem_w_reg_data(mem_w_reg_data), .mem_w_reg_en(mem_w_reg_en),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_hilo_wen(mem_hilo_wen), .mem_valid(mem_valid),
    .hilo_temp_out(hilo_temp_out), .cnt_out(cnt_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: what the memory slot and the feedback registers must contain.
  logic [4:0]  m_addr;
  logic [31:0] m_data, m_hi, m_lo;
  logic        m_en, m_hwen, m_valid;
  logic [63:0] m_temp;
  logic [1:0]  m_cnt;

  task automatic m_clear();
    m_addr = 0; m_data = 0; m_en = 0; m_hi = 0; m_lo = 0; m_hwen = 0; m_valid = 0;
    m_temp = 0; m_cnt = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) m_clear();
    else if (stall_ex && !stall_mem) begin
      logic [63:0] t;
      logic [1:0]  c;
      t = ex_hilo_temp; c = ex_cnt;
      m_clear();
      m_temp = t; m_cnt = c;
    end else if (!stall_ex && !stall_mem) begin
      m_addr = ex_w_reg_addr; m_data = ex_w_reg_data; m_en = ex_w_reg_en;
      m_hi = ex_hi; m_lo = ex_lo; m_hwen = ex_hilo_wen; m_valid = 1;
      m_temp = 0; m_cnt = 0;
    end
  end

  initial m_clear();

  always @(negedge clk) begin
    chk("cyc.addr",  64'(mem_w_reg_addr), 64'(m_addr));
    chk("cyc.data",  64'(mem_w_reg_data), 64'(m_data));
    chk("cyc.en",    64'(mem_w_reg_en),   64'(m_en));
    chk("cyc.hi",    64'(mem_hi),         64'(m_hi));
    chk("cyc.lo",    64'(mem_lo),         64'(m_lo));
    chk("cyc.hwen",  64'(mem_hilo_wen),   64'(m_hwen));
    chk("cyc.valid", 64'(mem_valid),      64'(m_valid));
    chk("cyc.temp",  hilo_temp_out,       m_temp);
    chk("cyc.cnt",   64'(cnt_out),        64'(m_cnt));
  end

  task automatic set_ctl(input logic se, input logic sm, input logic fl);
    stall_ex = se; stall_mem = sm; flush = fl;
  endtask

  task automatic set_gpr(input logic [4:0] a, input logic [31:0] d, input logic e);
    ex_w_reg_addr = a; ex_w_reg_data = d; ex_w_reg_en = e;
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l, input logic w,
                          input logic [63:0] t, input logic [1:0] c);
    ex_hi = h; ex_lo = l; ex_hilo_wen = w; ex_hilo_temp = t; ex_cnt = c;
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".valid"}, 64'(mem_valid), 0);
    chk({name, ".data"},  64'(mem_w_reg_data), 0);
    chk({name, ".en"},    64'(mem_w_reg_en), 0);
    chk({name, ".hi"},    64'(mem_hi), 0);
    chk({name, ".hwen"},  64'(mem_hilo_wen), 0);
    chk({name, ".temp"},  hilo_temp_out, 0);
    chk({name, ".cnt"},   64'(cnt_out), 0);
  endtask

  initial begin
    // Reset state
    edge1(); edge1();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Normal capture
    set_ctl(0, 0, 0); set_gpr(5'd3, 32'hDEADBEEF, 1); set_hilo(0, 0, 0, 0, 0);
    edge1();
    chk("norm.addr", 64'(mem_w_reg_addr), 3);
    chk("norm.data", 64'(mem_w_reg_data), 64'hDEADBEEF);
    chk("norm.valid", 64'(mem_valid), 1);

    // Capture with no write enables still marks the slot valid
    set_gpr(5'd9, 32'h5, 0);
    edge1();
    chk("nowen.valid", 64'(mem_valid), 1);
    chk("nowen.en", 64'(mem_w_reg_en), 0);

    // Bubble carries MAC progress, then capture clears it
    set_ctl(1, 0, 0); set_gpr(5'd7, 32'h77, 1); set_hilo(0, 0, 0, 64'h1_0000_0002, 2'd1);
    edge1();
    chk("bub.en", 64'(mem_w_reg_en), 0);
    chk("bub.valid", 64'(mem_valid), 0);
    chk("bub.temp", hilo_temp_out, 64'h1_0000_0002);
    chk("bub.cnt", 64'(cnt_out), 1);
    // Full hold keeps the carried MAC state
    set_ctl(1, 1, 0); set_hilo(0, 0, 0, 64'hAAAA, 2'd0);
    edge1();
    chk("bubhold.temp", hilo_temp_out, 64'h1_0000_0002);
    chk("bubhold.cnt", 64'(cnt_out), 1);
    set_ctl(0, 0, 0); set_hilo(0, 0, 0, 64'hFFFF, 2'd1);
    edge1();
    chk("bubrel.temp", hilo_temp_out, 0);
    chk("bubrel.cnt", 64'(cnt_out), 0);
    chk("bubrel.valid", 64'(mem_valid), 1);

    // Out-of-range counter stored as-is
    set_ctl(1, 0, 0); set_hilo(0, 0, 0, 64'h3, 2'd3);
    edge1();
    chk("cnt3", 64'(cnt_out), 3);

    // HI/LO load then hold for 3 edges with changing inputs
    set_ctl(0, 0, 0); set_gpr(5'd1, 32'h1, 0); set_hilo(32'h11, 32'h22, 1, 0, 0);
    edge1();
    set_ctl(1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      set_gpr(5'(i + 10), $urandom, 1); set_hilo($urandom, $urandom, 0, {$urandom, $urandom}, 2'(i));
      edge1();
      chk("hold.hi", 64'(mem_hi), 64'h11);
      chk("hold.lo", 64'(mem_lo), 64'h22);
      chk("hold.hwen", 64'(mem_hilo_wen), 1);
      chk("hold.valid", 64'(mem_valid), 1);
    end

    // Illegal stall_ex=0/stall_mem=1 behaves as hold
    set_ctl(0, 1, 0); set_hilo(32'h99, 32'h98, 0, 0, 0);
    edge1();
    chk("illegal.hi", 64'(mem_hi), 64'h11);
    chk("illegal.valid", 64'(mem_valid), 1);

    // Flush beats both stalls
    set_ctl(1, 1, 1);
    edge1();
    chk_all_zero("flush");

    // Async reset while valid
    set_ctl(0, 0, 0); set_gpr(5'd4, 32'h44, 1);
    edge1();
    chk("prerst.valid", 64'(mem_valid), 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("arst1");
    #1 rst_n = 1'b1;
    // Async reset mid-MAC
    set_ctl(1, 0, 0); set_hilo(0, 0, 0, 64'h1234, 2'd1);
    edge1();
    chk("premac.cnt", 64'(cnt_out), 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("arst2");
    #1 rst_n = 1'b1;
    set_ctl(0, 0, 0); set_gpr(5'd3, 32'hDEADBEEF, 1);
    edge1();
    chk("postrst.addr", 64'(mem_w_reg_addr), 3);
    chk("postrst.data", 64'(mem_w_reg_data), 64'hDEADBEEF);
    chk("postrst.valid", 64'(mem_valid), 1);

    // Mixed sequence checked only by the cycle model
    for (int i = 0; i < 40; i++) begin
      logic se, sm;
      se = 1'($urandom); sm = se & 1'($urandom);
      set_ctl(se, sm, ($urandom_range(0, 9) == 0));
      set_gpr(5'($urandom), $urandom, 1'($urandom));
      set_hilo($urandom, $urandom, 1'($urandom), {$urandom, $urandom}, 2'($urandom_range(0, 1)));
      edge1();
    end

    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
